// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: steps an external alu_cell through WIDTH bits, LSB first.
// Define ALU_SERIAL_SLT_EN to enable the two-pass signed set-less-than (op 11).
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             cell_a_invert,
  output logic             cell_b_invert,
  output logic [1:0]       cell_op,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_ci,
  output logic             cell_less,
  input  logic             cell_result,
  input  logic             cell_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
`ifdef ALU_SERIAL_SLT_EN
    SLT2 = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               a_inv_q, a_inv_d, b_inv_q, b_inv_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               carry_out_q, carry_out_d, overflow_q, overflow_d;
  logic               zero_q, zero_d, busy_q, busy_d, done_q, done_d;
`ifdef ALU_SERIAL_SLT_EN
  logic [WIDTH-1:0]   a_cp_q, a_cp_d, b_cp_q, b_cp_d;
  logic               set_q, set_d;
`endif

  logic last_bit;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cell_a_invert = 1'b0;
    cell_b_invert = 1'b0;
    cell_op       = 2'b00;
    cell_a        = 1'b0;
    cell_b        = 1'b0;
    cell_ci       = 1'b0;
    cell_less     = 1'b0;
    if (state_q == RUN) begin
      cell_a_invert = a_inv_q;
      cell_b_invert = b_inv_q;
      cell_a        = a_sh_q[0];
      cell_b        = b_sh_q[0];
      cell_ci       = carry_q;
`ifdef ALU_SERIAL_SLT_EN
      cell_op       = (op_q == 2'b11) ? 2'b10 : op_q;
`else
      cell_op       = op_q;
`endif
    end
`ifdef ALU_SERIAL_SLT_EN
    else if (state_q == SLT2) begin
      cell_a_invert = a_inv_q;
      cell_b_invert = b_inv_q;
      cell_a        = a_sh_q[0];
      cell_b        = b_sh_q[0];
      cell_ci       = carry_q;
      cell_op       = 2'b11;
      cell_less     = set_q & (cnt_q == '0);
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    a_inv_d     = a_inv_q;
    b_inv_d     = b_inv_q;
    op_d        = op_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef ALU_SERIAL_SLT_EN
    a_cp_d      = a_cp_q;
    b_cp_d      = b_cp_q;
    set_d       = set_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_inv_d = alu_ctl[3];
          b_inv_d = alu_ctl[2];
          op_d    = alu_ctl[1:0];
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          cnt_d   = '0;
          carry_d = alu_ctl[2];
          busy_d  = 1'b1;
`ifdef ALU_SERIAL_SLT_EN
          a_cp_d  = a_in;
          b_cp_d  = b_in;
`endif
        end
      end
      RUN: begin
        res_d   = {cell_result, res_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = cell_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          carry_out_d = cell_co;
          overflow_d  = cell_ci ^ cell_co;
`ifdef ALU_SERIAL_SLT_EN
          set_d       = cell_result ^ cell_ci ^ cell_co;
          if (op_q == 2'b11) begin
            state_d = SLT2;
            a_sh_d  = a_cp_q;
            b_sh_d  = b_cp_q;
            cnt_d   = '0;
            carry_d = b_inv_q;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            zero_d  = (res_d == '0);
          end
`else
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          zero_d  = (res_d == '0);
`endif
        end
      end
`ifdef ALU_SERIAL_SLT_EN
      SLT2: begin
        res_d   = {cell_result, res_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = cell_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          zero_d  = (res_d == '0);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_inv_q     <= 1'b0;
      b_inv_q     <= 1'b0;
      op_q        <= 2'b00;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ALU_SERIAL_SLT_EN
      a_cp_q      <= '0;
      b_cp_q      <= '0;
      set_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_inv_q     <= a_inv_d;
      b_inv_q     <= b_inv_d;
      op_q        <= op_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ALU_SERIAL_SLT_EN
      a_cp_q      <= a_cp_d;
      b_cp_q      <= b_cp_d;
      set_q       <= set_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial sequencer that drives one `alu_cell` for `WIDTH` cycles to perform a full-width ALU operation, least significant bit first. It sits directly upstream of the cell: it feeds the per-bit operands, control, carry-in and `less`, and captures `result`/`co` back into a shift register. It is used where area matters more than latency, and presents a start/done handshake to the datapath.

## Interface
- `WIDTH`, 32: operand width in bits, ≥ 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; accepted only in IDLE.
- `alu_ctl`  in  4  `[3]` a_invert, `[2]` b_invert, `[1:0]` op (00 and, 01 or, 10 add, 11 slt); sampled on accept.
- `a_in`, `b_in`  in  WIDTH each  operands; sampled on accept.
- `cell_a_invert`, `cell_b_invert`  out  1 each  to cell.
- `cell_op`  out  2  to cell.
- `cell_a`, `cell_b`, `cell_ci`, `cell_less`  out  1 each  to cell.
- `cell_result`, `cell_co`  in  1 each  from cell.
- `busy`  out  1  high from accept until DONE.
- `done`  out  1  one-cycle pulse; outputs below valid.
- `result`  out  WIDTH  final result; held until next accept.
- `zero`  out  1  `result == 0`.
- `carry_out`  out  1  `co` of MSB in the arithmetic pass.
- `overflow`  out  1  carry into MSB XOR carry out of MSB, arithmetic pass.

## Operation
- States: IDLE, RUN, SLT2, DONE.
- IDLE + `start`: latch control, load `a_in`/`b_in` into shift registers, set bit counter = 0, carry register = `alu_ctl[2]`, then go to RUN.
- RUN, each cycle:
  - Drive `cell_a`/`cell_b` = LSB of the shift registers, `cell_ci` = carry register, and the latched invert bits.
  - `cell_op` = latched op, except 10 when op = 11.
  - `cell_less` = 0.
  - On the edge: shift `cell_result` into `result` at the MSB end, shift operands right, carry register ← `cell_co`, counter + 1.
- At the MSB (counter = WIDTH−1):
  - Capture `carry_out` ← `cell_co`.
  - Capture `overflow` ← `cell_ci ^ cell_co`.
  - Capture `set` ← `cell_result ^ cell_ci ^ cell_co`.
  - Go to DONE, or to SLT2 if op = 11 and the SLT macro is defined.
- SLT2:
  - Reload the operands from a copy of the latched operands and clear the counter.
  - Drive `cell_op` = 11.
  - `cell_less` = `set` at counter 0, else 0.
  - Shift results as in RUN. After WIDTH cycles go to DONE.
- DONE: `done` = 1 for one cycle, `zero` is updated, then return to IDLE.
- Flag ownership: `carry_out` and `overflow` always come from the RUN pass.
- `start` while not in IDLE is ignored, with no queueing.
- Outside RUN/SLT2, every `cell_*` output is driven 0.
- `rst` in any state:
  - Next state IDLE.
  - `result`, `zero`, `carry_out`, `overflow`, `busy`, `done`, counter, carry and shift registers are cleared to 0.
  - An in-flight operation is discarded with no `done`.

## Timing
- Accept on edge T. RUN occupies cycles T+1 … T+WIDTH.
- `done` is high in cycle T+WIDTH+1. For SLT with the macro, it is high in T+2·WIDTH+1.
- `busy` is high from T+1 through the last RUN/SLT2 cycle, and low in DONE.
- A new `start` is accepted in the cycle after DONE at the earliest.
- Cell feedback is combinational within the cycle. The cell has no state.
- Counter width is `$clog2(WIDTH)`. Wrap is never reached because the state exits at WIDTH−1.

## Configuration
- `ALU_SERIAL_SLT_EN` defined: op = 11 runs the two-pass SLT described above.
- Not defined:
  - SLT2 is compiled out.
  - op = 11 runs a single RUN pass with `cell_op` = 11 and `cell_less` = 0, so `result` = 0.
  - `carry_out`/`overflow` still reflect the add of the inverted operands.
  - Latency is WIDTH+1.

## Test plan
WIDTH = 8, control values from `alu_ctl`:
- Add, ctl 0010, 0x7F + 0x01 → `result` 0x80, `overflow` 1, `carry_out` 0, `zero` 0, `done` 9 cycles after accept.
- Subtract, ctl 0110, 0x05 − 0x05 → `result` 0x00, `zero` 1, `carry_out` 1, `overflow` 0.
- AND 0xF0 & 0x3C → 0x30. OR → 0xFC. NOR (ctl 1100) of 0xF0, 0x0C → 0x03.
- SLT, ctl 0111, with the macro: 0xFD vs 0x02 → 0x01. 0x02 vs 0xFD → 0x00. 0x80 vs 0x7F (overflow case) → 0x01. `done` 17 cycles after accept.
- `start` pulsed mid-RUN with different operands → ignored, original result returned. Back-to-back start in the cycle after DONE is accepted.
- `rst` asserted at cycle 4 of RUN → next cycle IDLE, all outputs 0, no `done`. The following operation completes correctly.
